// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES inverse-cipher datapath.
package aes_dec_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  // 128-bit state or round key; byte 0 sits in [127:120]
  typedef logic [127:0] aes_block_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ark_state_t;

endpackage

// File: rtl/aes_dec_round_key_store.sv
// Round-key register file (NR+1 entries) with a loaded mask.
// Writes land only when the owner allows it and the index is in range;
// a rejected write pulses wr_err on the following cycle.
import aes_dec_pkg::*;

module aes_dec_round_key_store #(
  parameter int NR     = 10,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_allow,
  input  logic [RIDX_W-1:0] wr_idx,
  input  aes_block_t        wr_data,
  output logic              wr_err,
  input  logic [RIDX_W-1:0] rd_idx,
  output aes_block_t        rd_data,
  output logic              keys_ready
);

  localparam logic [RIDX_W-1:0] NR_IDX = RIDX_W'(NR);

  aes_block_t  keys [0:NR];
  logic [NR:0] loaded;
  logic        wr_take;

  assign wr_take = wr_en & wr_allow & (wr_idx <= NR_IDX);

  // key contents are deliberately not reset; the loaded mask guards them
  always_ff @(posedge clk) begin
    if (wr_take) keys[wr_idx] <= wr_data;
  end

  // loaded mask and write-reject pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded <= '0;
      wr_err <= 1'b0;
    end else begin
      if (wr_take) loaded[wr_idx] <= 1'b1;
      wr_err <= wr_en & ~wr_take;
    end
  end

  assign rd_data    = (rd_idx <= NR_IDX) ? keys[rd_idx] : '0;
  assign keys_ready = &loaded;

endmodule

// File: rtl/aes_dec_add_round_key.sv
// AddRoundKey stage of the iterative AES inverse cipher.
// Counts rounds down NR..0, XORs each beat with the matching round key and
// registers the result with round tags for the InvMixColumns stage.
// Optional build macro AES_DEC_ARK_SEQ_CHECK_EN adds a seq_err pulse for
// out-of-order block framing (first beat in ACTIVE, non-first beat in IDLE).
import aes_dec_pkg::*;

module aes_dec_add_round_key #(
  parameter int NR     = 10,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [RIDX_W-1:0] key_wr_idx,
  input  logic [127:0]      key_wr_data,
  output logic              key_wr_err,
  output logic              keys_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic [127:0]      data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      data_out,
  output logic [RIDX_W-1:0] out_round,
  output logic              out_mix,
  output logic              out_last
`ifdef AES_DEC_ARK_SEQ_CHECK_EN
  ,
  output logic              seq_err
`endif
);

  localparam logic [RIDX_W-1:0] NR_IDX = RIDX_W'(NR);

  ark_state_t        state, state_nxt;
  logic [RIDX_W-1:0] rcnt, rcnt_nxt, round_sel;
  logic              accept, restart, wr_allow;
  aes_block_t        round_key;

  assign in_ready  = keys_ready & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  // a first beat, or any beat while idle, starts a fresh block at key[NR]
  assign restart   = (state == IDLE) | in_first;
  assign round_sel = restart ? NR_IDX : rcnt;
  // keys may only change while nothing is in flight
  assign wr_allow  = (state == IDLE) & ~out_valid & ~accept;

  aes_dec_round_key_store #(.NR(NR), .RIDX_W(RIDX_W)) u_key_store (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (key_wr_en),
    .wr_allow   (wr_allow),
    .wr_idx     (key_wr_idx),
    .wr_data    (key_wr_data),
    .wr_err     (key_wr_err),
    .rd_idx     (round_sel),
    .rd_data    (round_key),
    .keys_ready (keys_ready)
  );

  // round sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // round sequencer next state: advance only on an accepted beat
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    if (accept) begin
      if (restart) begin
        if (NR > 0) begin
          state_nxt = ACTIVE;
          rcnt_nxt  = NR_IDX - RIDX_W'(1);
        end else begin
          state_nxt = IDLE;
        end
      end else if (rcnt == '0) begin
        state_nxt = IDLE;
      end else begin
        rcnt_nxt = rcnt - RIDX_W'(1);
      end
    end
  end

  // single output register; data and tags move only on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_round <= '0;
      out_mix   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        data_out  <= data_in ^ round_key;
        out_round <= round_sel;
        out_mix   <= (round_sel != '0) && (round_sel != NR_IDX);
        out_last  <= (round_sel == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef AES_DEC_ARK_SEQ_CHECK_EN
  // flag framing anomalies one cycle after the offending accept
  always_ff @(posedge clk) begin
    if (rst) seq_err <= 1'b0;
    else     seq_err <= accept & ((state == IDLE) ? ~in_first : in_first);
  end
`endif

endmodule

// File: tb/tb_aes_dec_add_round_key.sv
// Directed bench for aes_dec_add_round_key using the FIPS-197 C.1 schedule.
module tb_aes_dec_add_round_key;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_wr_en;
  logic [3:0]   key_wr_idx;
  logic [127:0] key_wr_data;
  logic         key_wr_err, keys_ready;
  logic         in_valid, in_ready, in_first;
  logic [127:0] data_in, data_out;
  logic         out_valid, out_ready;
  logic [3:0]   out_round;
  logic         out_mix, out_last;
`ifdef AES_DEC_ARK_SEQ_CHECK_EN
  logic         seq_err;
`endif

  int checks = 0;
  int passes = 0;

  logic [127:0] rk [0:10];

  aes_dec_add_round_key #(.NR(10), .RIDX_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .key_wr_err  (key_wr_err),
    .keys_ready  (keys_ready),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_first    (in_first),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .out_round   (out_round),
    .out_mix     (out_mix),
    .out_last    (out_last)
`ifdef AES_DEC_ARK_SEQ_CHECK_EN
    ,
    .seq_err     (seq_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input string tag, input logic [127:0] d, input int r);
    chk({tag, "_valid"}, 128'(out_valid), 128'(1));
    chk({tag, "_data"},  data_out, d);
    chk({tag, "_round"}, 128'(out_round), 128'(r));
    chk({tag, "_mix"},   128'(out_mix), 128'((r != 0 && r != 10) ? 1 : 0));
    chk({tag, "_last"},  128'(out_last), 128'((r == 0) ? 1 : 0));
  endtask

  task automatic write_key(input int idx, input logic [127:0] k);
    key_wr_en   = 1'b1;
    key_wr_idx  = 4'(idx);
    key_wr_data = k;
    tick();
    key_wr_en   = 1'b0;
  endtask

  task automatic beat(input logic first, input logic [127:0] d);
    in_valid = 1'b1;
    in_first = first;
    data_in  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    rst = 1'b1; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    in_valid = 1'b0; in_first = 1'b0; data_in = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_data_out", data_out, 128'h0);
    chk("rst_out_round", 128'(out_round), 128'(0));
    chk("rst_mix_last", {126'h0, out_mix, out_last}, 128'h0);
    chk("rst_keys_ready", 128'(keys_ready), 128'(0));
    chk("rst_key_wr_err", 128'(key_wr_err), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));

    // partial key load: 0..9 only
    for (int i = 0; i <= 9; i++) write_key(i, rk[i]);
    chk("partial_keys_ready", 128'(keys_ready), 128'(0));
    in_valid = 1'b1; #1;
    chk("partial_in_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b0;

    // out-of-range index is rejected
    write_key(11, 128'hdead);
    chk("idx11_err_pulse", 128'(key_wr_err), 128'(1));
    tick();
    chk("idx11_err_clear", 128'(key_wr_err), 128'(0));
    chk("idx11_mask", 128'(keys_ready), 128'(0));

    write_key(10, rk[10]);
    chk("full_keys_ready", 128'(keys_ready), 128'(1));
    chk("full_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 C.1 first inverse round input
    beat(1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk_result("fips", 128'h7ad5fda789ef4e272bca100b3d9ff59f, 10);

    // remaining 10 beats of the block, continuous flow
    for (int r = 9; r >= 0; r--) begin
      in_valid = 1'b1; in_first = 1'b0; data_in = 128'h0; #1;
      chk($sformatf("flow_in_ready_r%0d", r), 128'(in_ready), 128'(1));
      tick();
      chk_result($sformatf("blk_r%0d", r), rk[r], r);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 128'(out_valid), 128'(0));

    // backpressure: result held for 3 cycles with out_ready low
    beat(1'b1, 128'h0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_first = 1'b0; data_in = {128{1'b1}};
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall_in_ready_c%0d", c), 128'(in_ready), 128'(0));
      tick();
      chk_result($sformatf("stall_hold_c%0d", c), rk[10], 10);
    end
    out_ready = 1'b1; #1;
    chk("stall_release_in_ready", 128'(in_ready), 128'(1));
    tick();
    chk_result("stall_next", ~rk[9], 9);
    in_valid = 1'b0;
    tick();
    chk("stall_drain_valid", 128'(out_valid), 128'(0));

    // key write while the block is ACTIVE is rejected
    write_key(3, 128'h0);
    chk("active_wr_err", 128'(key_wr_err), 128'(1));
    tick();

    // rounds 8,7,6 then a first beat where round 5 was due
    for (int r = 8; r >= 6; r--) begin
      beat(1'b0, 128'h0);
      chk_result($sformatf("pre_r%0d", r), rk[r], r);
    end
    beat(1'b1, 128'h0);
    chk_result("restart", rk[10], 10);
`ifdef AES_DEC_ARK_SEQ_CHECK_EN
    chk("restart_seq_err", 128'(seq_err), 128'(1));
    tick();
    chk("restart_seq_err_clear", 128'(seq_err), 128'(0));
`endif
    for (int r = 9; r >= 0; r--) begin
      beat(1'b0, 128'h0);
      chk_result($sformatf("rst_blk_r%0d", r), rk[r], r);
    end

    // non-first beat in IDLE behaves as a first beat
    beat(1'b0, 128'h0);
    chk_result("idle_nonfirst", rk[10], 10);
`ifdef AES_DEC_ARK_SEQ_CHECK_EN
    chk("idle_nonfirst_seq_err", 128'(seq_err), 128'(1));
`endif
    beat(1'b0, 128'h0);
    chk_result("idle_nonfirst_next", rk[9], 9);

    // reset mid-block with a result pending
    beat(1'b0, 128'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk("midrst_keys_ready", 128'(keys_ready), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(0));

    for (int i = 0; i <= 10; i++) write_key(i, rk[i]);
    chk("reload_keys_ready", 128'(keys_ready), 128'(1));
    beat(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk_result("reload_fips", 128'h7ad5fda789ef4e272bca100b3d9ff59f, 10);
    beat(1'b0, 128'h0);
    chk_result("reload_r9", rk[9], 9);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
